// File: rtl/frame_buffer_alt_if.sv
// Bus interface for frame_buffer_alt: write/read enables (active-low),
// write data, registered read data and the two frame-done pulses.
// Pixel source / consumer side uses the master modport, the buffer uses slave.
interface frame_buffer_alt_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  wr_en_in;
  logic                  rd_en_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  wr_frame_done;
  logic                  rd_frame_done;

  modport master (
    output wr_en_in,
    output rd_en_in,
    output data_in,
    input  data_out,
    input  wr_frame_done,
    input  rd_frame_done
  );

  modport slave (
    input  wr_en_in,
    input  rd_en_in,
    input  data_in,
    output data_out,
    output wr_frame_done,
    output rd_frame_done
  );
endinterface

// File: rtl/frame_buffer_alt.sv
// frame_buffer_alt: single-clock simple dual-port frame buffer with
// independent auto-incrementing write and read address counters.
// Writes land at wr_addr, reads return mem[rd_addr] one clock later;
// both counters wrap modulo DEPTH and pulse a frame-done flag on wrap.
// Simultaneous access to the same address is read-before-write.
// Optional macro FB_OUT_REG_EN adds a second output register stage
// (2-clock read latency) and delays rd_frame_done to stay aligned.
module frame_buffer_alt #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input logic               clk,
  input logic               reset,
  frame_buffer_alt_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  wr_done_r;
  logic                  rd_done_r;

  logic                  wr_fire_s;
  logic                  rd_fire_s;

  // Reset dominates both enables: no access happens on a reset edge.
  assign wr_fire_s = reset & ~bus.wr_en_in;
  assign rd_fire_s = reset & ~bus.rd_en_in;

  // Memory array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_addr_r] <= bus.data_in;
    end
  end

  // Write address counter and write-wrap pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_addr_r <= {ADDR_WIDTH{1'b0}};
      wr_done_r <= 1'b0;
    end else if (wr_fire_s) begin
      wr_addr_r <= wr_addr_r + ADDR_ONE;
      wr_done_r <= (wr_addr_r == LAST_ADDR);
    end else begin
      wr_done_r <= 1'b0;
    end
  end

  // Read port (old contents on a same-address collision), read counter and wrap pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_addr_r <= {ADDR_WIDTH{1'b0}};
      data_r    <= {DATA_WIDTH{1'b0}};
      rd_done_r <= 1'b0;
    end else if (rd_fire_s) begin
      rd_addr_r <= rd_addr_r + ADDR_ONE;
      data_r    <= mem_r[rd_addr_r];
      rd_done_r <= (rd_addr_r == LAST_ADDR);
    end else begin
      rd_done_r <= 1'b0;
    end
  end

`ifdef FB_OUT_REG_EN
  logic [DATA_WIDTH-1:0] data2_r;
  logic                  rd_fire_d_r;
  logic                  rd_done2_r;

  // Second output stage: advances only when the first stage just loaded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data2_r     <= {DATA_WIDTH{1'b0}};
      rd_fire_d_r <= 1'b0;
      rd_done2_r  <= 1'b0;
    end else begin
      rd_fire_d_r <= rd_fire_s;
      rd_done2_r  <= rd_done_r;
      if (rd_fire_d_r) begin
        data2_r <= data_r;
      end else begin
        data2_r <= data2_r;
      end
    end
  end

  assign bus.data_out      = data2_r;
  assign bus.rd_frame_done = rd_done2_r;
`else
  assign bus.data_out      = data_r;
  assign bus.rd_frame_done = rd_done_r;
`endif

  assign bus.wr_frame_done = wr_done_r;

endmodule

// File: tb/tb_frame_buffer_alt.sv
// Self-checking bench for frame_buffer_alt: directed scenarios followed by
// randomized traffic, all compared against an array/pointer reference model.
module tb_frame_buffer_alt;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic reset;

  frame_buffer_alt_if #(.DATA_WIDTH(DW)) bus ();

  frame_buffer_alt #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model state
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_valid [DEPTH];
  int            m_wp, m_rp;
  logic [DW-1:0] m_s1, m_s2;
  bit            m_s1_known, m_s2_known;
  bit            m_rd_prev;
  bit            m_rdone1, m_rdone2, m_wdone;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, then check outputs.
  task automatic cycle(input bit rst_n, input bit wen_n, input bit ren_n, input logic [DW-1:0] din);
    logic [DW-1:0] exp_data;
    bit            exp_known;
    bit            exp_rdone;
    reset        = rst_n;
    bus.wr_en_in = wen_n;
    bus.rd_en_in = ren_n;
    bus.data_in  = din;
    @(posedge clk);
    if (!rst_n) begin
      m_wp = 0; m_rp = 0;
      m_s1 = '0; m_s1_known = 1'b1;
      m_s2 = '0; m_s2_known = 1'b1;
      m_rd_prev = 1'b0;
      m_rdone1 = 1'b0; m_rdone2 = 1'b0; m_wdone = 1'b0;
    end else begin
      if (m_rd_prev) begin
        m_s2 = m_s1;
        m_s2_known = m_s1_known;
      end
      m_rdone2  = m_rdone1;
      m_rd_prev = !ren_n;
      if (!ren_n) begin
        m_s1       = m_mem[m_rp];
        m_s1_known = m_valid[m_rp];
        m_rdone1   = (m_rp == DEPTH - 1);
        m_rp       = (m_rp + 1) % DEPTH;
      end else begin
        m_rdone1 = 1'b0;
      end
      if (!wen_n) begin
        m_mem[m_wp]   = din;
        m_valid[m_wp] = 1'b1;
        m_wdone       = (m_wp == DEPTH - 1);
        m_wp          = (m_wp + 1) % DEPTH;
      end else begin
        m_wdone = 1'b0;
      end
    end
`ifdef FB_OUT_REG_EN
    exp_data  = m_s2;
    exp_known = m_s2_known;
    exp_rdone = m_rdone2;
`else
    exp_data  = m_s1;
    exp_known = m_s1_known;
    exp_rdone = m_rdone1;
`endif
    #1;
    if (exp_known) check_eq("data_out", bus.data_out, exp_data);
    check_eq("wr_frame_done", {31'd0, bus.wr_frame_done}, {31'd0, m_wdone});
    check_eq("rd_frame_done", {31'd0, bus.rd_frame_done}, {31'd0, exp_rdone});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = '0;
      m_valid[i] = 1'b0;
    end
    reset        = 1'b0;
    bus.wr_en_in = 1'b1;
    bus.rd_en_in = 1'b1;
    bus.data_in  = 32'h0;
    @(negedge clk);

    // Reset held for two edges with both enables active
    cycle(1'b0, 1'b0, 1'b0, 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 32'h1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0);

    // Sequential write 2..6 then read with a hold after 3 appears
    cycle(1'b0, 1'b1, 1'b1, 32'h0);
    for (int i = 2; i <= 6; i++) cycle(1'b1, 1'b0, 1'b1, 32'(i));
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0);

    // Wrap: 16 words 10..1F, then 20 overwrites address 0, then read 16
    cycle(1'b0, 1'b1, 1'b1, 32'h0);
    for (int i = 16'h10; i <= 16'h20; i++) cycle(1'b1, 1'b0, 1'b1, 32'(i));
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0);

    // Same-address collision: both counters at 0, mem[0]=A, write B while reading
    cycle(1'b0, 1'b1, 1'b1, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'hA);
    for (int i = 1; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b1, 32'h100 + 32'(i));
    cycle(1'b1, 1'b0, 1'b0, 32'hB);
    for (int i = 1; i < DEPTH; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0);

    // Reset mid-operation after 3 writes and 1 read; reset edge carries active enables
    cycle(1'b0, 1'b1, 1'b1, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'hC0);
    cycle(1'b1, 1'b0, 1'b1, 32'hC1);
    cycle(1'b1, 1'b0, 1'b0, 32'hC2);
    cycle(1'b0, 1'b0, 1'b0, 32'h1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0),
            $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_buffer_alt.md
Name: frame_buffer_alt

Overview:
- Single-clock, simple dual-port frame buffer RAM with independent auto-incrementing write and read address counters.
- Upstream pixel source writes sequential 32-bit words; downstream consumer (display/stream side) reads them back in the same order.
- No host addressing: every access position comes from the internal counters.

Parameters:
- DATA_WIDTH, 32, width of stored words, data_in and data_out.
- ADDR_WIDTH, 4, address counter width; DEPTH = 2**ADDR_WIDTH words (default 16).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- wr_en_in  input  1  active-low write enable.
- rd_en_in  input  1  active-low read enable.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- wr_frame_done  output  1  one-cycle pulse when the write of address DEPTH-1 completes.
- rd_frame_done  output  1  one-cycle pulse when the read of address DEPTH-1 completes.

Behaviour:
- Reset (reset==0 at a rising edge):
  - wr_addr=0, rd_addr=0, data_out=0, wr_frame_done=0, rd_frame_done=0.
  - Memory contents are not cleared.
  - Reset dominates both enables; no write or read occurs in that cycle.
- Write (reset==1, wr_en_in==0): mem[wr_addr]<=data_in; wr_addr<=wr_addr+1 modulo DEPTH.
- Write idle (wr_en_in==1): wr_addr holds; no memory change.
- Read (reset==1, rd_en_in==0): data_out<=mem[rd_addr]; rd_addr<=rd_addr+1 modulo DEPTH.
  - Latency: 1 clock from the enabled edge to data_out.
- Read idle (rd_en_in==1): data_out and rd_addr hold their values.
- Wrap-around:
  - A write at wr_addr==DEPTH-1 sets wr_addr to 0 and sets wr_frame_done=1 for exactly the next cycle.
  - Reads behave the same way with rd_frame_done.
  - Neither flag is sticky.
- Simultaneous read and write at the same address: read-before-write. data_out gets the old contents; the new word is visible on the next read of that address.
- No full/empty protection:
  - Writes overwrite the oldest data.
  - Reads may pass the write pointer and return stale or uninitialised contents.
- Reset mid-frame: both counters return to 0 at the next edge; a partially written frame is abandoned.
- Both enables are sampled only on rising edges; glitches between edges have no effect.

Optional Feature:
- Macro FB_OUT_REG_EN.
- Defined:
  - Adds a second output pipeline register; read latency is 2 clocks.
  - The pipeline stage advances only on cycles where the read was enabled one cycle earlier.
  - rd_frame_done is delayed one extra cycle so it stays aligned with the last word of the frame on data_out.
  - Reset clears both stages to 0.
- Undefined: single output register, 1-clock latency as described above.

Test Plan:
- Reset: hold reset=0 for 2 edges with wr_en_in=0, rd_en_in=0, data_in=32'h1.
  - data_out=0 and both flags 0.
  - Release reset, then read with no prior write: address 0 is not written during reset.
- Sequential write/read:
  - After reset, write 32'h2,3,4,5,6 (wr_en_in=0, one per edge), then set wr_en_in=1.
  - Set rd_en_in=0: data_out shows 2,3,4,5,6 on consecutive cycles, 1 cycle after each enabled edge.
- Hold: deassert rd_en_in (=1) midway, after 32'h3 appears.
  - data_out stays 32'h3.
  - rd_addr resumes and the next read returns 32'h4.
- Wrap: write 16 words 32'h10..32'h1F.
  - wr_frame_done pulses once, the cycle after 32'h1F is written.
  - Word 17 (32'h20) overwrites address 0.
  - Reading 16 words returns 32'h20,11..1F, and rd_frame_done pulses after the last word.
- Same-address collision: mem[0]=32'hA, counters both at 0; wr_en_in=0 and rd_en_in=0 on the same edge with data_in=32'hB.
  - data_out=32'hA.
  - After the counters wrap back to address 0, a later read returns 32'hB.
- Reset mid-operation: assert reset after 3 writes and 1 read.
  - Counters return to 0 and data_out=0.
  - The next read returns the pre-reset mem[0].
  - With FB_OUT_REG_EN defined, the scenario-2 sequence appears 2 cycles after each enabled edge.
